// File: rtl/oracle_seq_pkg.sv
// Shared types and default widths for the oracle sequencer.
//   seq_state_e : sequencer FSM states
//   *_DFLT      : default frame / counter widths for an s713-class core
package oracle_seq_pkg;

    localparam int unsigned IN_W_DFLT    = 35;
    localparam int unsigned OUT_W_DFLT   = 23;
    localparam int unsigned DEPTH_W_DFLT = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WAIT_VEC = 3'd2,
        STEP     = 3'd3,
        RESP     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/oracle_seq_ctrl.sv
// Sequencer driving an unkeyed sequential core used as an attack oracle.
// Takes a depth-N command, clears the core, steps it once per accepted input
// frame and returns each captured output frame over a valid/ready stream.
//   CK, RN                          clock / async active-low reset
//   cmd_valid/cmd_ready/cmd_depth   command stream (depth 0 rejected via cmd_err)
//   abort                           level; returns to IDLE, drops any pending result
//   vec_valid/vec_ready/vec_data    input frame stream
//   res_valid/res_ready/res_data    output frame stream, res_last on final frame
//   busy                            not IDLE
//   core_clr/core_ce/core_in        controls into the core wrapper
//   core_out                        combinational core outputs
module oracle_seq_ctrl
    import oracle_seq_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DFLT,
    parameter int unsigned OUT_W   = OUT_W_DFLT,
    parameter int unsigned DEPTH_W = DEPTH_W_DFLT
) (
    input  logic               CK,
    input  logic               RN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DEPTH_W-1:0] cmd_depth,
    input  logic               abort,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [IN_W-1:0]    vec_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [OUT_W-1:0]   res_data,
    output logic               res_last,
    output logic               cmd_err,
    output logic               busy,
    output logic               core_clr,
    output logic               core_ce,
    output logic [IN_W-1:0]    core_in,
    input  logic [OUT_W-1:0]   core_out
);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] frame_cnt_q;

    logic cmd_fire;
    logic vec_fire;
    logic res_fire;

    logic cmd_ready_d;
    logic vec_ready_d;
    logic res_valid_d;
    logic busy_d;
    logic core_clr_d;
    logic core_ce_d;
    logic cmd_err_d;

    // Handshakes qualified by abort, which overrides every transfer in its cycle.
    assign cmd_fire = (state_q == IDLE) && cmd_valid && (cmd_depth != '0) && !abort;
    assign vec_fire = (state_q == WAIT_VEC) && vec_valid && !abort;
    assign res_fire = (state_q == RESP) && res_ready && !abort;

    // State register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (cmd_fire) state_d = CLEAR;
                CLEAR:    state_d = WAIT_VEC;
                WAIT_VEC: if (vec_fire) state_d = STEP;
                STEP:     state_d = RESP;
                RESP:     if (res_fire) state_d = res_last ? IDLE : WAIT_VEC;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state, so registered outputs line up with state_q.
    always_comb begin
        cmd_ready_d = 1'b0;
        vec_ready_d = 1'b0;
        res_valid_d = 1'b0;
        core_clr_d  = 1'b0;
        core_ce_d   = 1'b0;
        case (state_d)
            IDLE:     cmd_ready_d = 1'b1;
            CLEAR:    core_clr_d  = 1'b1;
            WAIT_VEC: vec_ready_d = 1'b1;
            STEP:     core_ce_d   = 1'b1;
            RESP:     res_valid_d = 1'b1;
            default:  ;
        endcase
        busy_d    = (state_d != IDLE);
        cmd_err_d = (state_q == IDLE) && cmd_valid && (cmd_depth == '0) && !abort;
    end

    // Output, counter and datapath registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cmd_ready   <= 1'b0;
            vec_ready   <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            core_clr    <= 1'b0;
            core_ce     <= 1'b0;
            cmd_err     <= 1'b0;
            res_data    <= '0;
            res_last    <= 1'b0;
            core_in     <= '0;
            depth_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            cmd_ready <= cmd_ready_d;
            vec_ready <= vec_ready_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
            core_clr  <= core_clr_d;
            core_ce   <= core_ce_d;
            cmd_err   <= cmd_err_d;

            if (cmd_fire) begin
                depth_q     <= cmd_depth;
                frame_cnt_q <= '0;
            end else if (res_fire && !res_last) begin
                frame_cnt_q <= frame_cnt_q + DEPTH_W'(1);
            end

            if (vec_fire) begin
                core_in <= vec_data;
            end

            // core_out still reflects the pre-step core state during STEP.
            if (state_q == STEP) begin
                res_data <= core_out;
                res_last <= (frame_cnt_q == (depth_q - DEPTH_W'(1)));
            end
        end
    end

endmodule
